// File: rtl/simplez_pkg.sv
// Shared constants, types and helpers for the Simplez memory-mapped I/O block.
// Addresses are the 9-bit Simplez I/O window; status bit positions are fixed here.
package simplez_pkg;

  localparam logic [8:0] IO_BASE     = 9'd507;
  localparam logic [8:0] ADDR_LEDS   = 9'd507;
  localparam logic [8:0] ADDR_STATUS = 9'd508;
  localparam logic [8:0] ADDR_TXDATA = 9'd509;
  localparam logic [2:0] IO_SPAN     = 3'd5;

  localparam int unsigned STAT_TX_READY = 32'd0;
  localparam int unsigned STAT_OVERFLOW = 32'd1;
  localparam int unsigned STAT_TX_BUSY  = 32'd2;

  localparam logic [2:0] FIFO_DEPTH = 3'd4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [2:0] pack_status(input logic tx_ready,
                                             input logic overflow,
                                             input logic tx_busy);
    logic [2:0] s;
    s = 3'd0;
    s[STAT_TX_READY] = tx_ready;
    s[STAT_OVERFLOW] = overflow;
    s[STAT_TX_BUSY]  = tx_busy;
    return s;
  endfunction

endpackage

// File: rtl/simplez_io_if.sv
// CPU-side bus of the Simplez I/O block: strobes, address, data and window select.
interface simplez_io_if #(
  parameter int ADDRW = 9,
  parameter int DATAW = 12
) ();

  logic [ADDRW-1:0] addr;
  logic             rd;
  logic             wr;
  logic [DATAW-1:0] data_in;
  logic [DATAW-1:0] data_out;
  logic             sel;

  modport master (output addr, rd, wr, data_in, input data_out, sel);
  modport slave  (input addr, rd, wr, data_in, output data_out, sel);

endinterface

// File: rtl/uart_tx.sv
// 8N1 serial transmitter; accepts a byte only in IDLE (ready) and drives tx from a register.
module uart_tx
  import simplez_pkg::*;
#(
  parameter int BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(32'd1);
  localparam logic [BW-1:0] BAUD_ZERO = BW'(32'd0);

  tx_state_e     state_r, state_s;
  logic [BW-1:0] baud_r, baud_s;
  logic [2:0]    bit_r, bit_s;
  logic [7:0]    shift_r, shift_s;
  logic          tx_r, tx_s;
  logic          baud_end_s;

  assign baud_end_s = (baud_r == BAUD_LAST);
  assign ready      = (state_r == TX_IDLE);
  assign tx         = tx_r;

  // State register; reset aborts any frame and returns the line to idle-high.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= TX_IDLE;
      baud_r  <= BAUD_ZERO;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
    end
  end

  // Next state; tx_s is the line level for the cycle after this edge.
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    tx_s    = tx_r;
    case (state_r)
      TX_IDLE: begin
        baud_s = BAUD_ZERO;
        bit_s  = 3'd0;
        if (valid) begin
          shift_s = data;
          state_s = TX_START;
          tx_s    = 1'b0;
        end else begin
          tx_s    = 1'b1;
        end
      end
      TX_START: begin
        if (baud_end_s) begin
          baud_s  = BAUD_ZERO;
          state_s = TX_DATA;
          tx_s    = shift_r[0];
        end else begin
          baud_s  = baud_r + BAUD_ONE;
        end
      end
      TX_DATA: begin
        if (baud_end_s) begin
          baud_s  = BAUD_ZERO;
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            bit_s   = 3'd0;
            state_s = TX_STOP;
            tx_s    = 1'b1;
          end else begin
            bit_s   = bit_r + 3'd1;
            tx_s    = shift_r[1];
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      TX_STOP: begin
        tx_s = 1'b1;
        if (baud_end_s) begin
          baud_s  = BAUD_ZERO;
          state_s = TX_IDLE;
        end else begin
          baud_s  = baud_r + BAUD_ONE;
        end
      end
      default: begin
        state_s = TX_IDLE;
        baud_s  = BAUD_ZERO;
        bit_s   = 3'd0;
        tx_s    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/simplez_io.sv
// Simplez memory-mapped I/O: LED register, status register and a 4-deep FIFO
// feeding the serial transmitter. Reads return registered data one cycle later.
module simplez_io
  import simplez_pkg::*;
#(
  parameter int ADDRW    = 9,
  parameter int DATAW    = 12,
  parameter int BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       rstn,
  simplez_io_if.slave bus,
  output logic [3:0] leds,
  output logic       tx
);

  localparam logic [ADDRW-1:0] A_BASE   = ADDRW'(IO_BASE);
  localparam logic [ADDRW-1:0] A_LEDS   = ADDRW'(ADDR_LEDS);
  localparam logic [ADDRW-1:0] A_STATUS = ADDRW'(ADDR_STATUS);
  localparam logic [ADDRW-1:0] A_TXDATA = ADDRW'(ADDR_TXDATA);

  logic [ADDRW-1:0] off_s;
  logic             sel_s, hit_leds_s, hit_status_s, hit_tx_s;
  logic [3:0]       leds_r;
  logic [DATAW-1:0] dout_r, rdata_s;
  logic             ovf_r, ovf_set_s, ovf_clr_s;
  logic [7:0]       fifo_r [4];
  logic [1:0]       wptr_r, rptr_r;
  logic [2:0]       count_r, count_s;
  logic             tx_ready_s, tx_busy_s, uart_ready_s;
  logic             push_try_s, push_s, pop_s;
  logic             unused_s;

  assign off_s        = bus.addr - A_BASE;
  assign sel_s        = (bus.addr >= A_BASE) && (off_s < ADDRW'(IO_SPAN));
  assign hit_leds_s   = (bus.addr == A_LEDS);
  assign hit_status_s = (bus.addr == A_STATUS);
  assign hit_tx_s     = (bus.addr == A_TXDATA);

  assign tx_ready_s = (count_r < FIFO_DEPTH);
  assign tx_busy_s  = !uart_ready_s;
  assign pop_s      = (count_r != 3'd0) && uart_ready_s;
  // A simultaneous pop frees a slot, so a write to a full FIFO is still accepted then.
  assign push_try_s = bus.wr && hit_tx_s;
  assign push_s     = push_try_s && (tx_ready_s || pop_s);
  assign ovf_set_s  = push_try_s && !push_s;
  assign ovf_clr_s  = bus.wr && hit_status_s && bus.data_in[STAT_OVERFLOW];

  assign bus.sel      = sel_s;
  assign bus.data_out = dout_r;
  assign leds         = leds_r;
  assign unused_s     = ^bus.data_in[DATAW-1:8];

  // Read mux and FIFO occupancy for the coming edge.
  always_comb begin
    rdata_s = {DATAW{1'b0}};
    count_s = count_r;
    if (bus.rd && hit_leds_s) begin
      rdata_s = DATAW'(leds_r);
    end else if (bus.rd && hit_status_s) begin
      rdata_s = DATAW'(pack_status(tx_ready_s, ovf_r, tx_busy_s));
    end else begin
      rdata_s = {DATAW{1'b0}};
    end
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + 3'd1;
      2'b01:   count_s = count_r - 3'd1;
      default: count_s = count_r;
    endcase
  end

  // Registers: LEDs, read data, overflow flag and FIFO storage/pointers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      leds_r  <= 4'd0;
      dout_r  <= {DATAW{1'b0}};
      ovf_r   <= 1'b0;
      wptr_r  <= 2'd0;
      rptr_r  <= 2'd0;
      count_r <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_r[i] <= 8'd0;
      end
    end else begin
      dout_r  <= rdata_s;
      count_r <= count_s;
      if (bus.wr && hit_leds_s) begin
        leds_r <= bus.data_in[3:0];
      end
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr_s) begin
        ovf_r <= 1'b0;
      end
      if (push_s) begin
        fifo_r[wptr_r] <= bus.data_in[7:0];
        wptr_r         <= wptr_r + 2'd1;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + 2'd1;
      end
    end
  end

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart_tx (
    .clk   (clk),
    .rstn  (rstn),
    .valid (count_r != 3'd0),
    .data  (fifo_r[rptr_r]),
    .ready (uart_ready_s),
    .tx    (tx)
  );

endmodule

// File: tb/tb_simplez_io.sv
// Bench for simplez_io: register vector table, serial frame / overflow / reset
// sequences, and a randomized run against a frame-position reference model.
module tb_simplez_io;

  localparam int ADDRW = 9;
  localparam int DATAW = 12;
  localparam int BAUD  = 4;
  localparam int FRAME = 10 * BAUD;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] leds;
  logic       tx;

  simplez_io_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

  simplez_io #(.ADDRW(ADDRW), .DATAW(DATAW), .BAUD_DIV(BAUD)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .leds (leds),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [8:0]  addr;
    logic [11:0] din;
    logic        exp_sel;
    logic [11:0] exp_dout;
    logic [3:0]  exp_leds;
  } vec_t;

  vec_t vecs [15];

  // reference model state
  logic [3:0]  m_leds;
  logic        m_ovf;
  logic [7:0]  m_q [$];
  int          m_pos;
  logic [7:0]  m_byte;
  logic [11:0] m_dout;
  logic        m_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic w, input logic [8:0] a, input logic [11:0] d);
    bus.rd = r; bus.wr = w; bus.addr = a; bus.data_in = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 9'd0, 12'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic model_reset();
    m_leds = 4'd0; m_ovf = 1'b0; m_q.delete(); m_pos = -1; m_byte = 8'd0; m_dout = 12'd0;
  endtask

  // One clock edge of the specified behaviour; serial timing by frame position.
  task automatic model_step(input logic r, input logic w, input int a, input logic [11:0] d);
    logic busy, ready, pop;
    logic [11:0] rv;
    busy  = (m_pos >= 0);
    ready = (m_q.size() < 4);
    m_sel = (a >= 507) && (a <= 511);
    rv = 12'd0;
    if (a == 507) rv = {8'd0, m_leds};
    else if (a == 508) rv = {9'd0, busy, m_ovf, ready};
    m_dout = (r && m_sel) ? rv : 12'd0;
    pop = !busy && (m_q.size() > 0);
    if (pop) begin
      m_byte = m_q.pop_front();
      m_pos = 0;
    end else if (busy) begin
      m_pos++;
      if (m_pos == FRAME) m_pos = -1;
    end
    if (w && a == 509) begin
      if (m_q.size() < 4) m_q.push_back(d[7:0]);
      else m_ovf = 1'b1;
    end else if (w && a == 508 && d[1]) begin
      m_ovf = 1'b0;
    end
    if (w && a == 507) m_leds = d[3:0];
  endtask

  function automatic logic model_tx();
    if (m_pos < 0) return 1'b1;
    if (m_pos < BAUD) return 1'b0;
    if (m_pos < 9 * BAUD) return m_byte[(m_pos - BAUD) / BAUD];
    return 1'b1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] frame_byte;
    logic       exp_tx;
    int         lat;
    int         lows;

    //               rd    wr    addr    din      sel   dout     leds
    vecs[0]  = '{1'b0, 1'b1, 9'd507, 12'h005, 1'b1, 12'h000, 4'h5};
    vecs[1]  = '{1'b1, 1'b0, 9'd507, 12'h000, 1'b1, 12'h005, 4'h5};
    vecs[2]  = '{1'b0, 1'b0, 9'd000, 12'h000, 1'b0, 12'h000, 4'h5};
    vecs[3]  = '{1'b1, 1'b0, 9'd510, 12'h000, 1'b1, 12'h000, 4'h5};
    vecs[4]  = '{1'b1, 1'b0, 9'd100, 12'h000, 1'b0, 12'h000, 4'h5};
    vecs[5]  = '{1'b0, 1'b1, 9'd100, 12'h00A, 1'b0, 12'h000, 4'h5};
    vecs[6]  = '{1'b0, 1'b1, 9'd510, 12'h00A, 1'b1, 12'h000, 4'h5};
    vecs[7]  = '{1'b0, 1'b1, 9'd511, 12'h00C, 1'b1, 12'h000, 4'h5};
    vecs[8]  = '{1'b1, 1'b1, 9'd507, 12'h0FA, 1'b1, 12'h005, 4'hA};
    vecs[9]  = '{1'b1, 1'b0, 9'd507, 12'h000, 1'b1, 12'h00A, 4'hA};
    vecs[10] = '{1'b1, 1'b0, 9'd509, 12'h000, 1'b1, 12'h000, 4'hA};
    vecs[11] = '{1'b1, 1'b0, 9'd506, 12'h000, 1'b0, 12'h000, 4'hA};
    vecs[12] = '{1'b1, 1'b0, 9'd511, 12'h000, 1'b1, 12'h000, 4'hA};
    vecs[13] = '{1'b1, 1'b0, 9'd508, 12'h000, 1'b1, 12'h001, 4'hA};
    vecs[14] = '{1'b0, 1'b1, 9'd508, 12'h002, 1'b1, 12'h000, 4'hA};

    do_reset();
    check("reset_dout", bus.data_out, 12'h000);
    check("reset_leds", leds, 4'h0);
    check("reset_tx", tx, 1'b1);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din);
      #1;
      check($sformatf("vec%0d_sel", i), bus.sel, vecs[i].exp_sel);
      tick();
      check($sformatf("vec%0d_dout", i), bus.data_out, vecs[i].exp_dout);
      check($sformatf("vec%0d_leds", i), leds, vecs[i].exp_leds);
    end
    idle();

    // single frame of 0x55
    do_reset();
    frame_byte = 8'h55;
    drive(1'b0, 1'b1, 9'd509, 12'h055);
    tick();
    idle();
    lat = 0;
    while (tx !== 1'b0 && lat < 20) begin
      tick();
      lat++;
    end
    check("frame_start_latency", lat, 1);
    for (int k = 0; k < FRAME; k++) begin
      if (k < BAUD) exp_tx = 1'b0;
      else if (k < 9 * BAUD) exp_tx = frame_byte[(k - BAUD) / BAUD];
      else exp_tx = 1'b1;
      check($sformatf("frame_tx_cycle%0d", k), tx, exp_tx);
      if (k == 10) drive(1'b1, 1'b0, 9'd508, 12'h000);
      if (k == 11) begin
        check("frame_status_busy", bus.data_out, 12'h005);
        idle();
      end
      tick();
    end
    check("frame_end_tx", tx, 1'b1);
    drive(1'b1, 1'b0, 9'd508, 12'h000);
    tick();
    idle();
    check("frame_end_status", bus.data_out, 12'h001);

    // overflow: six back-to-back TXDATA writes
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 9'd509, 12'h0A0 + 12'(i));
      tick();
    end
    drive(1'b1, 1'b0, 9'd508, 12'h000);
    tick();
    check("ovf_status_set", bus.data_out, 12'h006);
    drive(1'b0, 1'b1, 9'd508, 12'h005);
    tick();
    drive(1'b1, 1'b0, 9'd508, 12'h000);
    tick();
    check("ovf_not_cleared_bit1_0", bus.data_out, 12'h006);
    drive(1'b0, 1'b1, 9'd508, 12'h002);
    tick();
    drive(1'b1, 1'b0, 9'd508, 12'h000);
    tick();
    check("ovf_cleared", bus.data_out, 12'h004);

    // reset in the middle of DATA with bytes still queued
    drive(1'b0, 1'b1, 9'd507, 12'h003);
    tick();
    idle();
    for (int i = 0; i < 4; i++) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("midreset_tx", tx, 1'b1);
    check("midreset_leds", leds, 4'h0);
    check("midreset_dout", bus.data_out, 12'h000);
    drive(1'b1, 1'b0, 9'd508, 12'h000);
    tick();
    idle();
    check("midreset_status", bus.data_out, 12'h001);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx === 1'b0) lows++;
    end
    check("midreset_queue_discarded", lows, 0);

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int          pick;
      logic        r, w;
      logic [8:0]  a;
      logic [11:0] d;
      pick = int'($urandom_range(0, 99));
      a = 9'($urandom_range(507, 511));
      d = 12'($urandom);
      r = 1'b0;
      w = 1'b0;
      if (pick < 8) begin w = 1'b1; a = 9'd509; end
      else if (pick < 12) begin w = 1'b1; a = 9'd508; end
      else if (pick < 18) begin w = 1'b1; a = 9'd507; end
      else if (pick < 35) r = 1'b1;
      else if (pick < 40) begin r = 1'b1; a = 9'($urandom_range(0, 511)); end
      else if (pick < 43) begin r = 1'b1; w = 1'b1; end
      else if (pick < 47) begin
        w = 1'b1;
        a = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(510, 511)) : 9'($urandom_range(0, 506));
      end
      else a = 9'($urandom_range(0, 511));
      drive(r, w, a, d);
      model_step(r, w, int'(a), d);
      #1;
      check($sformatf("rand%0d_sel", c), bus.sel, m_sel);
      tick();
      check($sformatf("rand%0d_dout", c), bus.data_out, m_dout);
      check($sformatf("rand%0d_leds", c), leds, m_leds);
      check($sformatf("rand%0d_tx", c), tx, model_tx());
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
